// File: rtl/commit_retire_unit.sv
// In-order retirement of the oldest scoreboard entries.
// Drives RF commit writes, store commit, fence drain and traps.
package commit_retire_pkg;
  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_LOAD, FU_STORE,
    FU_AMO, FU_FENCE, FU_CSR, FU_FPU
  } fu_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            valid;
    fu_t             fu;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    exception_t      ex;
  } scoreboard_entry_t;
endpackage

module commit_retire_unit
  import commit_retire_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int CNT_W           = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      halt_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
  output logic [NR_COMMIT_PORTS-1:0] commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0] waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] wdata_o,
  output logic [NR_COMMIT_PORTS-1:0] we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0] we_fpr_o,
  output logic                      commit_lsu_o,
  input  logic                      commit_lsu_ready_i,
  output logic                      fence_o,
  input  logic                      no_st_pending_i,
  output exception_t                exception_o,
  output logic [CNT_W-1:0]          instret_o
);

  typedef enum logic [1:0] {
    RUN, FENCE_DRAIN, TRAP_WAIT
  } state_t;

  state_t            state_q, state_d;
  scoreboard_entry_t head;
  logic              blocked;
  logic              is_mem;
  logic              trap;
  logic              go;
  logic [CNT_W-1:0]  retired;
  logic              unused_fields;

  assign head    = commit_instr_i[0];
  assign blocked = rst_i | flush_i | halt_i;
  assign is_mem  = (head.fu == FU_STORE) |
                   (head.fu == FU_AMO);
  assign unused_fields = ^commit_instr_i;

  always_comb begin
    state_d      = state_q;
    commit_ack_o = '0;
    commit_lsu_o = 1'b0;
    fence_o      = 1'b0;
    exception_o  = '0;
    trap         = 1'b0;
    go           = 1'b0;
    unique case (state_q)
      RUN: begin
        if (head.valid && !blocked) begin
          unique case (1'b1)
            head.ex.valid: begin
              exception_o     = head.ex;
              commit_ack_o[0] = 1'b1;
              trap            = 1'b1;
              state_d         = TRAP_WAIT;
            end
            !head.ex.valid && is_mem: begin
              commit_lsu_o    = 1'b1;
              commit_ack_o[0] = commit_lsu_ready_i;
              go              = commit_lsu_ready_i;
            end
            !head.ex.valid &&
            head.fu == FU_FENCE: begin
              state_d = FENCE_DRAIN;
            end
            default: begin
              commit_ack_o[0] = 1'b1;
              go = (head.fu != FU_CSR);
            end
          endcase
        end
      end
      FENCE_DRAIN: begin
        fence_o = !rst_i;
        if (no_st_pending_i && !blocked) begin
          commit_ack_o[0] = head.valid;
          state_d         = RUN;
        end
      end
      TRAP_WAIT: begin
      end
      default: state_d = RUN;
    endcase
    // younger ports retire only behind an unbroken run of plain acks
    for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
      go = go &&
           commit_instr_i[k].valid &&
           !commit_instr_i[k].ex.valid &&
           commit_instr_i[k].fu != FU_STORE &&
           commit_instr_i[k].fu != FU_AMO &&
           commit_instr_i[k].fu != FU_FENCE &&
           commit_instr_i[k].fu != FU_CSR;
      commit_ack_o[k] = go;
    end
    if (flush_i || rst_i) state_d = RUN;
  end

  always_comb begin
    we_gpr_o = '0;
    we_fpr_o = '0;
    waddr_o  = '0;
    wdata_o  = '0;
    retired  = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      logic wr;
      logic fp;
      fp = commit_instr_i[k].fu == FU_FPU;
      wr = commit_ack_o[k] &&
           !(k == 0 && trap) &&
           commit_instr_i[k].fu != FU_STORE &&
           commit_instr_i[k].fu != FU_FENCE;
      we_fpr_o[k] = wr && fp;
      we_gpr_o[k] = wr && !fp &&
                    commit_instr_i[k].rd != 5'd0;
      if (commit_instr_i[k].valid) begin
        waddr_o[k] = commit_instr_i[k].rd;
        wdata_o[k] = commit_instr_i[k].result;
      end
      retired = retired + CNT_W'(
        commit_ack_o[k] && !(k == 0 && trap));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      instret_o <= '0;
    end else begin
      state_q   <= state_d;
      instret_o <= instret_o + retired;
    end
  end

endmodule

// File: tb/tb_commit_retire_unit.sv
// Directed bench for commit_retire_unit with a
// scoreboard of expected per-cycle outputs.
module tb_commit_retire_unit;
  import commit_retire_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, halt, lsu_rdy, nsp;
  scoreboard_entry_t [1:0] instr;
  logic [1:0] ack, we_gpr, we_fpr;
  logic [1:0][4:0] waddr;
  logic [1:0][XLEN-1:0] wdata;
  logic lsu, fence;
  exception_t exc;
  logic [3:0] instret;

  commit_retire_unit #(
    .NR_COMMIT_PORTS(2),
    .CNT_W(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .halt_i(halt),
    .commit_instr_i(instr),
    .commit_ack_o(ack),
    .waddr_o(waddr),
    .wdata_o(wdata),
    .we_gpr_o(we_gpr),
    .we_fpr_o(we_fpr),
    .commit_lsu_o(lsu),
    .commit_lsu_ready_i(lsu_rdy),
    .fence_o(fence),
    .no_st_pending_i(nsp),
    .exception_o(exc),
    .instret_o(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] wg;
    logic [1:0] wf;
    logic l;
    logic f;
    logic x;
  } exp_t;

  exp_t exp_q[$];
  int ncmp = 0;
  int nerr = 0;
  logic [3:0] m_instret = 4'd0;

  function automatic scoreboard_entry_t ent(
    input fu_t fu, input logic [4:0] rd,
    input logic exv);
    scoreboard_entry_t r;
    r = '0;
    r.valid = 1'b1;
    r.fu = fu;
    r.rd = rd;
    r.result = 64'hD000_0000_0000_0000 | 64'(rd);
    r.ex.valid = exv;
    r.ex.cause = exv ? 64'd2 : 64'd0;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] a,
                     input logic [1:0] wg,
                     input logic [1:0] wf,
                     input logic l,
                     input logic f,
                     input logic x);
    exp_t e;
    exp_q.push_back('{a, wg, wf, l, f, x});
    #2;
    e = exp_q.pop_front();
    chk("ack", 64'(ack), 64'(e.a));
    chk("we_gpr", 64'(we_gpr), 64'(e.wg));
    chk("we_fpr", 64'(we_fpr), 64'(e.wf));
    chk("commit_lsu", 64'(lsu), 64'(e.l));
    chk("fence", 64'(fence), 64'(e.f));
    chk("exc_valid", 64'(exc.valid), 64'(e.x));
    @(posedge clk);
    if (rst)
      m_instret = 4'd0;
    else
      m_instret = m_instret + 4'(e.a[0])
                + 4'(e.a[1]) - 4'(e.x);
    #1;
    chk("instret", 64'(instret), 64'(m_instret));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    halt = 1'b0;
    lsu_rdy = 1'b0;
    nsp = 1'b0;
    instr = '0;
    @(posedge clk);
    #1;
    instr[0] = ent(FU_ALU, 5'd1, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b0;

    instr[0] = ent(FU_ALU, 5'd5, 1'b0);
    instr[1] = ent(FU_ALU, 5'd6, 1'b0);
    #1;
    chk("waddr0", 64'(waddr[0]), 64'd5);
    chk("wdata1", wdata[1], 64'hD000_0000_0000_0006);
    cyc(2'b11, 2'b11, 2'b00, 0, 0, 0);

    instr[0] = ent(FU_STORE, 5'd0, 1'b0);
    instr[1] = '0;
    #1;
    chk("waddr1_inv", 64'(waddr[1]), 64'd0);
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 2'b00, 1, 0, 0);
    lsu_rdy = 1'b1;
    cyc(2'b01, 2'b00, 2'b00, 1, 0, 0);

    instr[0] = ent(FU_AMO, 5'd9, 1'b0);
    cyc(2'b01, 2'b01, 2'b00, 1, 0, 0);
    lsu_rdy = 1'b0;

    instr[0] = ent(FU_FPU, 5'd0, 1'b0);
    instr[1] = ent(FU_ALU, 5'd3, 1'b0);
    cyc(2'b11, 2'b10, 2'b01, 0, 0, 0);

    instr[0] = ent(FU_CSR, 5'd7, 1'b0);
    instr[1] = ent(FU_ALU, 5'd8, 1'b0);
    cyc(2'b01, 2'b01, 2'b00, 0, 0, 0);

    instr[0] = ent(FU_FENCE, 5'd0, 1'b0);
    instr[1] = ent(FU_ALU, 5'd2, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(2'b00, 2'b00, 2'b00, 0, 1, 0);
    nsp = 1'b1;
    cyc(2'b01, 2'b00, 2'b00, 0, 1, 0);
    nsp = 1'b0;
    instr[0] = ent(FU_ALU, 5'd2, 1'b0);
    instr[1] = '0;
    cyc(2'b01, 2'b01, 2'b00, 0, 0, 0);

    instr[0] = ent(FU_ALU, 5'd0, 1'b0);
    instr[1] = ent(FU_ALU, 5'd4, 1'b1);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 0);
    instr[0] = ent(FU_ALU, 5'd4, 1'b1);
    instr[1] = ent(FU_ALU, 5'd5, 1'b0);
    #1;
    chk("exc_cause", exc.cause, 64'd2);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 1);
    instr[0] = ent(FU_ALU, 5'd5, 1'b0);
    instr[1] = '0;
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    flush = 1'b1;
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    flush = 1'b0;
    cyc(2'b01, 2'b01, 2'b00, 0, 0, 0);

    halt = 1'b1;
    instr[0] = ent(FU_ALU, 5'd1, 1'b0);
    instr[1] = ent(FU_ALU, 5'd2, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    instr[0] = ent(FU_STORE, 5'd0, 1'b0);
    instr[1] = '0;
    lsu_rdy = 1'b1;
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    halt = 1'b0;
    cyc(2'b01, 2'b00, 2'b00, 1, 0, 0);
    lsu_rdy = 1'b0;

    flush = 1'b1;
    instr[0] = ent(FU_ALU, 5'd10, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    flush = 1'b0;

    for (int i = 0; i < 16 && m_instret != 4'hF; i++)
      cyc(2'b01, 2'b01, 2'b00, 0, 0, 0);
    instr[1] = ent(FU_ALU, 5'd11, 1'b0);
    cyc(2'b11, 2'b11, 2'b00, 0, 0, 0);
    chk("instret_wrap", 64'(instret), 64'd1);

    instr[0] = ent(FU_FENCE, 5'd0, 1'b0);
    instr[1] = '0;
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 1, 0);
    rst = 1'b1;
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b0;
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 1, 0);
    nsp = 1'b1;
    cyc(2'b01, 2'b00, 2'b00, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
